// File: rtl/wb_regfile.sv
// wb_regfile: write-back result select, integer register file with write-through
// bypass on the decode read ports, debug read port and retired-write counter.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [AW-1:0]   RdW,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [CNTW-1:0] wr_count
);
    logic [XLEN-1:0] regs [NREGS];
    logic            commit;
    logic            rs1_ok, rs2_ok, dbg_ok;

    assign ResultW = ResultSrcW == 2'b00 ? ALUResultW :
                     ResultSrcW == 2'b01 ? ReadDataW  :
                     ResultSrcW == 2'b10 ? PCPlus4W   : '0;

    // indices outside the implemented file are dropped on write and read as 0
    assign commit = RegWriteW && RdW != '0 && 32'(RdW) < NREGS && !reset;
    assign rs1_ok = !reset && Rs1D != '0 && 32'(Rs1D) < NREGS;
    assign rs2_ok = !reset && Rs2D != '0 && 32'(Rs2D) < NREGS;
    assign dbg_ok = !reset && dbg_addr != '0 && 32'(dbg_addr) < NREGS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            wr_count <= '0;
        end else if (commit) begin
            regs[RdW] <= ResultW;
            wr_count  <= wr_count + CNTW'(1);
        end
    end

    assign RD1D     = !rs1_ok ? '0 : (commit && RdW == Rs1D) ? ResultW : regs[Rs1D];
    assign RD2D     = !rs2_ok ? '0 : (commit && RdW == Rs2D) ? ResultW : regs[Rs2D];
    assign dbg_data = dbg_ok ? regs[dbg_addr] : '0;
endmodule
